// File: rtl/dist_ram_pkg.sv
// Shared defaults and types for the single-port distributed RAM.
//   AW     : default address width (depth = 2**AW)
//   DW     : default data word width
//   addr_t : address word type for the default configuration
//   data_t : data word type for the default configuration
package dist_ram_pkg;

    localparam int unsigned AW = 6;
    localparam int unsigned DW = 16;

    typedef logic [AW-1:0] addr_t;
    typedef logic [DW-1:0] data_t;

    // Number of words addressable with an aw-bit address.
    function automatic int unsigned depth_of(input int unsigned aw);
        return 32'(1) << aw;
    endfunction

endpackage

// File: rtl/my_dist_ram.sv
// Single-port distributed (LUT) RAM with a shared read/write address.
// Ports:
//   clk       : clock, all state updates on the rising edge
//   qspo_srst : synchronous active-high clear of the qspo register only
//   we        : write enable
//   a         : shared read/write address
//   d         : write data
//   spo       : combinational read data, mem[a]
//   qspo      : registered read data (read-first), cleared by qspo_srst
module my_dist_ram
    import dist_ram_pkg::*;
#(
    parameter int unsigned   AW       = dist_ram_pkg::AW,
    parameter int unsigned   DW       = dist_ram_pkg::DW,
    parameter logic [DW-1:0] INIT_VAL = '0
) (
    input  logic          clk,
    input  logic          qspo_srst,
    input  logic          we,
    input  logic [AW-1:0] a,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] spo,
    output logic [DW-1:0] qspo
);

    localparam int unsigned DEPTH = depth_of(AW);

    // Storage has power-up content only; it is never reset.
    logic [DW-1:0] mem [DEPTH] = '{default: INIT_VAL};

    // Output register powers up cleared so qspo is 0 before the first edge.
    logic [DW-1:0] qspo_q = '0;

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[a] <= d;
        end
    end

    // Registered read samples the pre-write word (read-first); clear wins.
    always_ff @(posedge clk) begin
        if (qspo_srst) begin
            qspo_q <= '0;
        end else begin
            qspo_q <= mem[a];
        end
    end

    // Asynchronous read path, intentionally unregistered.
    assign spo  = mem[a];
    assign qspo = qspo_q;

    // Simulation checks: defined write controls, and clear takes effect.
    a_we_known : assert property (@(posedge clk) !$isunknown(we));
    a_addr_known : assert property (@(posedge clk) we |-> !$isunknown(a));
    a_srst_clears : assert property (@(posedge clk) qspo_srst |=> (qspo == '0));

endmodule

// File: tb/tb_my_dist_ram.sv
module tb_my_dist_ram;

    localparam int unsigned AW    = 6;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 64;

    logic          clk = 1'b0;
    logic          qspo_srst = 1'b0;
    logic          we = 1'b0;
    logic [AW-1:0] a = '0;
    logic [DW-1:0] d = '0;
    logic [DW-1:0] spo;
    logic [DW-1:0] qspo;

    int n_cmp = 0;
    int n_bad = 0;
    bit run_cmp = 1'b0;

    // Reference memory and expected registered read.
    logic [DW-1:0] mem_m [DEPTH];
    logic [DW-1:0] qspo_m = '0;

    my_dist_ram #(.AW(AW), .DW(DW), .INIT_VAL('0)) dut (
        .clk(clk), .qspo_srst(qspo_srst), .we(we), .a(a), .d(d),
        .spo(spo), .qspo(qspo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Model: registered read takes the old word, then the write lands.
    always @(posedge clk) begin
        logic [DW-1:0] old_word;
        old_word = mem_m[a];
        qspo_m   = qspo_srst ? '0 : old_word;
        if (we) mem_m[a] = d;
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (run_cmp) begin
            check("model_spo", spo, mem_m[a]);
            check("model_qspo", qspo, qspo_m);
        end
    end

    // Drive inputs shortly after a rising edge, return at the following falling edge.
    task automatic step(input logic srst, input logic w, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        @(posedge clk);
        #2;
        qspo_srst = srst;
        we        = w;
        a         = addr;
        d         = data;
        @(negedge clk);
    endtask

    initial begin
        logic [DW-1:0] wdata;
        for (int i = 0; i < int'(DEPTH); i++) mem_m[i] = '0;

        #1;
        check("powerup_qspo", qspo, 16'h0000);
        check("powerup_spo", spo, 16'h0000);
        run_cmp = 1'b1;

        // Reset two cycles.
        step(1'b1, 1'b0, 6'd0, 16'h0);
        step(1'b1, 1'b0, 6'd0, 16'h0);
        check("rst_qspo", qspo, 16'h0000);
        check("rst_spo", spo, 16'h0000);

        // Write burst.
        step(1'b0, 1'b1, 6'd0, 16'h1234);
        step(1'b0, 1'b1, 6'd1, 16'hBEEF);
        step(1'b0, 1'b1, 6'd2, 16'h0001);
        step(1'b0, 1'b1, 6'd3, 16'hFFFF);

        // Read-back: spo immediate, qspo one cycle later.
        step(1'b0, 1'b0, 6'd0, 16'h0);
        check("rb0_spo", spo, 16'h1234);
        check("wr3_qspo_old", qspo, 16'h0000);
        step(1'b0, 1'b0, 6'd1, 16'h0);
        check("rb1_spo", spo, 16'hBEEF);
        check("rb0_qspo", qspo, 16'h1234);
        step(1'b0, 1'b0, 6'd2, 16'h0);
        check("rb2_spo", spo, 16'h0001);
        check("rb1_qspo", qspo, 16'hBEEF);
        step(1'b0, 1'b0, 6'd3, 16'h0);
        check("rb3_spo", spo, 16'hFFFF);
        check("rb2_qspo", qspo, 16'h0001);
        step(1'b0, 1'b0, 6'd3, 16'h0);
        check("rb3_qspo", qspo, 16'hFFFF);

        // Read-during-write on the same address.
        step(1'b0, 1'b1, 6'd7, 16'h5555);
        step(1'b0, 1'b0, 6'd7, 16'h0);
        check("rdw_spo_new", spo, 16'h5555);
        check("rdw_qspo_old", qspo, 16'h0000);
        step(1'b0, 1'b0, 6'd7, 16'h0);
        check("rdw_qspo_new", qspo, 16'h5555);

        // Clear in the middle of a read.
        step(1'b0, 1'b0, 6'd2, 16'h0);
        step(1'b1, 1'b0, 6'd2, 16'h0);
        check("mid_qspo_before", qspo, 16'h0001);
        step(1'b0, 1'b0, 6'd2, 16'h0);
        check("mid_qspo_clr", qspo, 16'h0000);
        check("mid_spo_kept", spo, 16'h0001);
        step(1'b0, 1'b0, 6'd2, 16'h0);
        check("mid_qspo_after", qspo, 16'h0001);

        // Write while the output register is held in clear.
        step(1'b1, 1'b1, 6'd5, 16'hA5A5);
        step(1'b0, 1'b0, 6'd5, 16'h0);
        check("wrst_spo", spo, 16'hA5A5);
        check("wrst_qspo_clr", qspo, 16'h0000);
        step(1'b0, 1'b0, 6'd5, 16'h0);
        check("wrst_qspo", qspo, 16'hA5A5);

        // Full sweep in groups of four, each group read back.
        for (int g = 0; g < int'(DEPTH) / 4; g++) begin
            for (int k = 0; k < 4; k++) begin
                wdata = DW'($urandom_range(1, 16'hFFFF));
                step(1'b0, 1'b1, AW'(g * 4 + k), wdata);
            end
            for (int k = 0; k < 4; k++) begin
                step(1'b0, 1'b0, AW'(g * 4 + k), 16'h0);
            end
        end
        // Wrap from the top address back to zero.
        step(1'b0, 1'b0, 6'd63, 16'h0);
        step(1'b0, 1'b0, 6'd0, 16'h0);
        step(1'b0, 1'b0, 6'd0, 16'h0);
        check("sweep_nonzero_63", (mem_m[63] != '0) ? 16'h1 : 16'h0, 16'h1);

        run_cmp = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
